// File: rtl/carry_select.sv
// carry_select: registered WIDTH-bit carry-select adder, {Cout,Sum} = A + B + Cin.
//
// The operand is split into WIDTH/BLOCK blocks. Block 0 is one ripple-carry
// adder fed by Cin. Every later block runs two ripple-carry adders in parallel
// (carry-in 0 and carry-in 1), and the carry out of the previous block picks
// one of them. The result is registered, so the latency is one cycle. There is
// no handshake: a new operation is accepted on every clock edge.
//
// Optional feature: define CARRY_SELECT_OVF_EN to add the Ovf output. Ovf is
// the registered signed overflow: carry into the MSB XOR carry out of the MSB.
//
// WIDTH must be a multiple of BLOCK.
module carry_select #(
    parameter int WIDTH = 8,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
`ifdef CARRY_SELECT_OVF_EN
    output logic             Ovf,
`endif
    output logic             Cout
);

    localparam int NBLK = WIDTH / BLOCK;

    // w_carry[g] is the carry into block g; w_carry[NBLK] is the carry out of the MSB.
    logic [NBLK:0]      w_carry;
    logic [WIDTH-1:0]   w_sum;
`ifdef CARRY_SELECT_OVF_EN
    logic               w_cmsb;   // carry into the MSB bit position
`endif

    assign w_carry[0] = Cin;

    for (genvar g = 0; g < NBLK; g++) begin : g_blk
        logic [BLOCK-1:0] w_a;
        logic [BLOCK-1:0] w_b;

        assign w_a = A[g*BLOCK +: BLOCK];
        assign w_b = B[g*BLOCK +: BLOCK];

        if (g == 0) begin : g_first
            // Single ripple chain driven directly by Cin.
            logic [BLOCK:0]   w_c;
            logic [BLOCK-1:0] w_s;

            assign w_c[0] = w_carry[0];
            for (genvar b = 0; b < BLOCK; b++) begin : g_fa
                assign w_s[b]   = w_a[b] ^ w_b[b] ^ w_c[b];
                assign w_c[b+1] = (w_a[b] & w_b[b]) | (w_c[b] & (w_a[b] ^ w_b[b]));
            end

            assign w_sum[g*BLOCK +: BLOCK] = w_s;
            assign w_carry[g+1]            = w_c[BLOCK];
`ifdef CARRY_SELECT_OVF_EN
            if (g == NBLK-1) begin : g_msb
                assign w_cmsb = w_c[BLOCK-1];
            end
`endif
        end else begin : g_sel
            // Two speculative ripple chains: w_c0 assumes carry-in 0, w_c1 carry-in 1.
            logic [BLOCK:0]   w_c0;
            logic [BLOCK:0]   w_c1;
            logic [BLOCK-1:0] w_s0;
            logic [BLOCK-1:0] w_s1;

            assign w_c0[0] = 1'b0;
            assign w_c1[0] = 1'b1;
            for (genvar b = 0; b < BLOCK; b++) begin : g_fa
                assign w_s0[b]   = w_a[b] ^ w_b[b] ^ w_c0[b];
                assign w_c0[b+1] = (w_a[b] & w_b[b]) | (w_c0[b] & (w_a[b] ^ w_b[b]));
                assign w_s1[b]   = w_a[b] ^ w_b[b] ^ w_c1[b];
                assign w_c1[b+1] = (w_a[b] & w_b[b]) | (w_c1[b] & (w_a[b] ^ w_b[b]));
            end

            // The real carry from the previous block selects the matching result.
            assign w_sum[g*BLOCK +: BLOCK] = w_carry[g] ? w_s1 : w_s0;
            assign w_carry[g+1]            = w_carry[g] ? w_c1[BLOCK] : w_c0[BLOCK];
`ifdef CARRY_SELECT_OVF_EN
            if (g == NBLK-1) begin : g_msb
                assign w_cmsb = w_carry[g] ? w_c1[BLOCK-1] : w_c0[BLOCK-1];
            end
`endif
        end
    end

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
`ifdef CARRY_SELECT_OVF_EN
    logic             r_ovf;
`endif

    // Output register: reset has priority, otherwise capture this cycle's result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
`ifdef CARRY_SELECT_OVF_EN
            r_ovf  <= 1'b0;
`endif
        end else begin
            r_sum  <= w_sum;
            r_cout <= w_carry[NBLK];
`ifdef CARRY_SELECT_OVF_EN
            r_ovf  <= w_cmsb ^ w_carry[NBLK];
`endif
        end
    end

    assign Sum  = r_sum;
    assign Cout = r_cout;
`ifdef CARRY_SELECT_OVF_EN
    assign Ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_carry_select.sv
// tb_carry_select: table-driven directed vectors, reset sequences and a
// randomized back-to-back stream against an arithmetic reference model.
// Build with or without CARRY_SELECT_OVF_EN; the Ovf checks follow the macro.
module tb_carry_select;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    always #5 clk = ~clk;

    carry_select #(.WIDTH(W), .BLOCK(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .A    (a),
        .B    (b),
        .Cin  (cin),
        .Sum  (sum),
`ifdef CARRY_SELECT_OVF_EN
        .Ovf  (ovf),
`endif
        .Cout (cout)
    );

`ifndef CARRY_SELECT_OVF_EN
    assign ovf = 1'b0;
`endif

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Expected packed as {ovf, cout, sum[W-1:0]}.
    task automatic check_out(input string name, input logic [W+1:0] exp);
        check({name, ".cout_sum"}, {23'd0, cout, sum}, {23'd0, exp[W:0]});
`ifdef CARRY_SELECT_OVF_EN
        check({name, ".ovf"}, {31'd0, ovf}, {31'd0, exp[W+1]});
`endif
    endtask

    // ---------------- reference model ----------------
    // Plain integer addition; signed overflow from operand/result signs.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mc);
        int          full;
        logic [W-1:0] s;
        logic         c;
        logic         v;
        full = int'(ma) + int'(mb) + int'(mc);
        s    = full[W-1:0];
        c    = full[W];
        v    = (ma[W-1] == mb[W-1]) && (s[W-1] != ma[W-1]);
        return {v, c, s};
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic [W-1:0] da, input logic [W-1:0] db, input logic dc);
        a   = da;
        b   = db;
        cin = dc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    vec_t tbl[$];

    // Scoreboard for the streamed random phase.
    logic [W+1:0] exp_q[$];

    initial begin
        tbl.push_back('{"p96_71_c0", 8'h96, 8'h71, 1'b0, 8'h07, 1'b1, 1'b0});
        tbl.push_back('{"p96_71_c1", 8'h96, 8'h71, 1'b1, 8'h08, 1'b1, 1'b0});
        tbl.push_back('{"p54_35_c1", 8'h54, 8'h35, 1'b1, 8'h8A, 1'b0, 1'b1});
        tbl.push_back('{"p54_35_c0", 8'h54, 8'h35, 1'b0, 8'h89, 1'b0, 1'b1});
        tbl.push_back('{"p00_24",    8'h00, 8'h24, 1'b0, 8'h24, 1'b0, 1'b0});
        tbl.push_back('{"zero",      8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0});
        tbl.push_back('{"xblk_0f",   8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0});
        tbl.push_back('{"xblk_ff",   8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0});
        tbl.push_back('{"ones",      8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0});
        tbl.push_back('{"neg_ovf",   8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1});

        // Reset held for two edges with live data on the inputs.
        rst = 1'b1;
        drive(8'h96, 8'h71, 1'b1);
        tick();
        check_out("rst_edge1", '0);
        tick();
        check_out("rst_edge2", '0);
        rst = 1'b0;
        tick();
        check_out("rst_release", {1'b0, 1'b1, 8'h08});

        // Directed vectors back to back, one per cycle.
        foreach (tbl[i]) begin
            drive(tbl[i].a, tbl[i].b, tbl[i].cin);
            tick();
            check_out(tbl[i].name, {tbl[i].exp_ovf, tbl[i].exp_cout, tbl[i].exp_sum});
        end

        // Mid-stream reset clears on that edge; the next edge registers current inputs.
        drive(8'hFF, 8'hFF, 1'b1);
        tick();
        check_out("pre_mid_rst", {1'b0, 1'b1, 8'hFF});
        rst = 1'b1;
        drive(8'h54, 8'h35, 1'b1);
        tick();
        check_out("mid_rst", '0);
        rst = 1'b0;
        tick();
        check_out("mid_rst_release", {1'b1, 1'b0, 8'h8A});

        // Randomized stream: a new vector every cycle, result one cycle later.
        begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            logic [W+1:0] e;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            drive(ra, rb, rc);
            exp_q.push_back(model(ra, rb, rc));
            for (int n = 0; n < 3000; n++) begin
                tick();
                e = exp_q.pop_front();
                if ({cout, sum} !== e[W:0] || ovf !== (e[W+1] & dut_has_ovf())) begin
                    check("rand", {22'd0, ovf, cout, sum}, {22'd0, e[W+1] & dut_has_ovf(), e[W:0]});
                end else begin
                    n_cmp++;
                end
                ra = W'($urandom);
                rb = W'($urandom);
                rc = 1'($urandom);
                drive(ra, rb, rc);
                exp_q.push_back(model(ra, rb, rc));
            end
            // Sweep every A against 64 random B values with both carry-ins.
            for (int ia = 0; ia < 256; ia++) begin
                for (int k = 0; k < 128; k++) begin
                    tick();
                    e = exp_q.pop_front();
                    if ({cout, sum} !== e[W:0] || ovf !== (e[W+1] & dut_has_ovf())) begin
                        check("sweep", {22'd0, ovf, cout, sum}, {22'd0, e[W+1] & dut_has_ovf(), e[W:0]});
                    end else begin
                        n_cmp++;
                    end
                    ra = W'(ia);
                    if (k[0] == 1'b0) rb = W'($urandom_range(0, 255));
                    rc = k[0];
                    drive(ra, rb, rc);
                    exp_q.push_back(model(ra, rb, rc));
                end
            end
            tick();
            e = exp_q.pop_front();
            check_out("stream_tail", e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // 1 when the Ovf output exists in this build; masks the model's Ovf otherwise.
    function automatic logic dut_has_ovf();
`ifdef CARRY_SELECT_OVF_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
